// File: rtl/loader_pkg.sv
// Shared definitions for the RAM loader: FSM state encoding, ioctl field
// widths and the running-checksum helper.
package loader_pkg;

  // Widths of the ioctl download interface fields.
  localparam int IDX_W    = 8;
  localparam int IOADDR_W = 25;
  localparam int BYTE_W   = 8;

  // Loader operating states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Modulo-256 running sum of bytes written during a load.
  function automatic logic [BYTE_W-1:0] csum_add(
    input logic [BYTE_W-1:0] sum,
    input logic [BYTE_W-1:0] data
  );
    return sum + data;
  endfunction

endpackage

// File: rtl/ram_loader.sv
// RAM loader: zero-fills a RAM on request and copies ioctl download bytes
// into it. Writes appear on we/waddr/wdata one cycle after the ioctl strobe.
// A download aimed at this loader always pre-empts a zero-fill; the
// interrupted fill is re-queued and restarts from address 0 afterwards.
module ram_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned INDEX      = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  input  logic                  ioctl_download,
  input  logic [IDX_W-1:0]      ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [IOADDR_W-1:0]   ioctl_addr,
  input  logic [BYTE_W-1:0]     ioctl_dout,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  loaded,
  output logic [BYTE_W-1:0]     csum
);

  // One extra bit so the subtraction of the base address can show a borrow.
  localparam int                    OFF_W     = IOADDR_W + 1;
  localparam logic [OFF_W-1:0]      BASE_EXT  = OFF_W'(BASE_ADDR);
  localparam logic [IDX_W-1:0]      INDEX_V   = IDX_W'(INDEX);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);

  state_e                  state_q, state_d;
  logic                    clear_pending_q, clear_pending_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    loaded_q, loaded_d;
  logic [BYTE_W-1:0]       csum_q, csum_d;

  logic                    active_s;
  logic [OFF_W-1:0]        addr_ext_s;
  logic [OFF_W-1:0]        offset_s;
  logic                    in_range_s;
  logic                    strobe_ok_s;

  // Decode whether the current download targets this loader and whether the
  // strobed byte address falls inside the RAM window.
  always_comb begin
    active_s    = ioctl_download && (ioctl_index == INDEX_V);
    addr_ext_s  = {1'b0, ioctl_addr};
    offset_s    = addr_ext_s - BASE_EXT;
    in_range_s  = (addr_ext_s >= BASE_EXT) &&
                  ((offset_s >> ADDR_WIDTH) == {OFF_W{1'b0}});
    strobe_ok_s = ioctl_wr && active_s && in_range_s;
  end

  // Next-state and next-output logic for the IDLE / CLEAR / LOAD sequencer.
  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q | clear_req;
    we_d            = 1'b0;
    waddr_d         = waddr_q;
    wdata_d         = wdata_q;
    done_d          = 1'b0;
    loaded_d        = loaded_q;
    csum_d          = csum_q;

    case (state_q)
      ST_IDLE: begin
        if (active_s) begin
          state_d = ST_LOAD;
          csum_d  = {BYTE_W{1'b0}};
        end else if (clear_pending_q) begin
          // Entering CLEAR consumes the request; a fresh pulse this very
          // cycle stays queued for another full fill.
          state_d         = ST_CLEAR;
          clear_pending_d = clear_req;
          we_d            = 1'b1;
          waddr_d         = {ADDR_WIDTH{1'b0}};
          wdata_d         = {DATA_WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        if (active_s) begin
          // Download wins: stop filling now and re-queue the whole fill.
          state_d         = ST_LOAD;
          clear_pending_d = 1'b1;
          csum_d          = {BYTE_W{1'b0}};
        end else if (waddr_q == ADDR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + ADDR_ONE;
          wdata_d = {DATA_WIDTH{1'b0}};
        end
      end

      ST_LOAD: begin
        if (!active_s) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          loaded_d = 1'b1;
        end else if (strobe_ok_s) begin
          we_d    = 1'b1;
          waddr_d = offset_s[ADDR_WIDTH-1:0];
          wdata_d = DATA_WIDTH'(ioctl_dout);
          csum_d  = csum_add(csum_q, ioctl_dout);
        end else begin
          we_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any fill or load in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      clear_pending_q <= 1'b0;
      we_q            <= 1'b0;
      waddr_q         <= {ADDR_WIDTH{1'b0}};
      wdata_q         <= {DATA_WIDTH{1'b0}};
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      loaded_q        <= 1'b0;
      csum_q          <= {BYTE_W{1'b0}};
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      we_q            <= we_d;
      waddr_q         <= waddr_d;
      wdata_q         <= wdata_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      loaded_q        <= loaded_d;
      csum_q          <= csum_d;
    end
  end

  assign we     = we_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign loaded = loaded_q;
  assign csum   = csum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader with a 16-entry RAM at ioctl base 0x100.
module tb_ram_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int BASE  = 32'h100;
  localparam int IDX   = 1;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear_req;
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          loaded;
  logic [7:0]    csum;

  int vectors     = 0;
  int miscompares = 0;

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .INDEX(IDX)) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
    .loaded(loaded), .csum(csum)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    step(); step();
    vectors++;
    if ({we, waddr, wdata, busy, done, loaded, csum} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 000000", {we, waddr, wdata, busy, done, loaded, csum});
    end
    reset_n = 1'b1;
    step(); step();
    vectors++;
    if ({we, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release_idle got we/busy=%b want 00", {we, busy});
    end
  endtask

  task automatic test_clear();
    int n = 0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    while (we !== 1'b1 && n < 8) begin step(); n++; end
    vectors++;
    if (we !== 1'b1) begin miscompares++; $display("FAIL clear_start timeout we=%b want 1", we); end
    for (int k = 0; k < DEPTH; k++) begin
      vectors++;
      if ({we, busy, waddr, wdata} !== {1'b1, 1'b1, 4'(k), 8'h00}) begin
        miscompares++;
        $display("FAIL clear_word%0d got we=%b busy=%b waddr=%0d wdata=%h want 1 1 %0d 00", k, we, busy, waddr, wdata, k);
      end
      step();
    end
    vectors++;
    if ({we, busy} !== 2'b00) begin miscompares++; $display("FAIL clear_end got we/busy=%b want 00", {we, busy}); end
  endtask

  task automatic test_load();
    logic [7:0] b [3];
    logic [7:0] sum = 8'h00;
    b[0] = 8'hAA; b[1] = 8'h55; b[2] = 8'h01;
    ioctl_index = 8'd1; ioctl_download = 1'b1; step();
    vectors++;
    if ({busy, we, csum} !== {1'b1, 1'b0, 8'h00}) begin
      miscompares++; $display("FAIL load_entry got busy=%b we=%b csum=%h want 1 0 00", busy, we, csum);
    end
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(BASE + i); ioctl_dout = b[i];
      step();
      sum = sum + b[i];
      vectors++;
      if ({we, waddr, wdata, csum} !== {1'b1, 4'(i), b[i], sum}) begin
        miscompares++;
        $display("FAIL load_write%0d got we=%b waddr=%0d wdata=%h csum=%h want 1 %0d %h %h", i, we, waddr, wdata, csum, i, b[i], sum);
      end
    end
    ioctl_wr = 1'b0; step();
    vectors++;
    if ({we, waddr, wdata} !== {1'b0, 4'd2, 8'h01}) begin
      miscompares++; $display("FAIL load_hold got we=%b waddr=%0d wdata=%h want 0 2 01", we, waddr, wdata);
    end
    ioctl_download = 1'b0; step();
    vectors++;
    if ({done, loaded, busy, csum} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      miscompares++; $display("FAIL load_done got done=%b loaded=%b busy=%b csum=%h want 1 1 0 00", done, loaded, busy, csum);
    end
    step();
    vectors++;
    if ({done, loaded} !== 2'b01) begin miscompares++; $display("FAIL load_done_pulse got done/loaded=%b want 01", {done, loaded}); end
  endtask

  task automatic test_out_of_range();
    int bad [3];
    bad[0] = 32'h0FF; bad[1] = BASE + DEPTH; bad[2] = 32'h1FF_FFFF;
    ioctl_index = 8'd1; ioctl_download = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(bad[i]); ioctl_dout = 8'h5A; step();
      vectors++;
      if ({we, csum} !== 9'h000) begin
        miscompares++; $display("FAIL oor_addr_%h got we=%b csum=%h want 0 00", bad[i], we, csum);
      end
    end
    ioctl_addr = 25'(BASE + DEPTH - 1); ioctl_dout = 8'h3C; step();
    vectors++;
    if ({we, waddr, wdata, csum} !== {1'b1, 4'd15, 8'h3C, 8'h3C}) begin
      miscompares++; $display("FAIL oor_top_word got we=%b waddr=%0d wdata=%h csum=%h want 1 15 3c 3c", we, waddr, wdata, csum);
    end
    ioctl_addr = 25'(BASE + DEPTH); ioctl_dout = 8'h11; step();
    vectors++;
    if ({we, waddr, wdata, csum} !== {1'b0, 4'd15, 8'h3C, 8'h3C}) begin
      miscompares++; $display("FAIL oor_after_top got we=%b waddr=%0d wdata=%h csum=%h want 0 15 3c 3c", we, waddr, wdata, csum);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0; step(); step();
  endtask

  task automatic test_wrong_index();
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(BASE + i); ioctl_dout = 8'(i + 1); step();
      vectors++;
      if ({we, busy} !== 2'b00) begin miscompares++; $display("FAIL wrong_index%0d got we/busy=%b want 00", i, {we, busy}); end
    end
    idle_inputs(); step();
  endtask

  task automatic test_random();
    logic [7:0] model_mem [DEPTH];
    bit         model_wr  [DEPTH];
    logic [7:0] dut_mem   [DEPTH];
    bit         dut_wr    [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin model_wr[i] = 0; dut_wr[i] = 0; model_mem[i] = 8'h00; dut_mem[i] = 8'h00; end
    for (int t = 0; t < 6; t++) begin
      logic [7:0] exp_sum = 8'h00;
      int ncyc = $urandom_range(4, 14);
      ioctl_index = 8'd1; ioctl_download = 1'b1; ioctl_wr = 1'b0; step();
      vectors++;
      if (csum !== 8'h00) begin miscompares++; $display("FAIL rnd%0d_csum_reset got %h want 00", t, csum); end
      for (int c = 0; c < ncyc; c++) begin
        int  a  = 32'hF8 + $urandom_range(0, 32);
        bit  w  = ($urandom_range(0, 3) != 0);
        bit  ok;
        logic [7:0] d = 8'($urandom_range(0, 255));
        if (c == ncyc - 1) begin w = 1; a = BASE + $urandom_range(0, DEPTH - 1); end
        ok = w && (a >= BASE) && (a < BASE + DEPTH);
        ioctl_wr = w; ioctl_addr = 25'(a); ioctl_dout = d;
        step();
        if (we === 1'b1) begin dut_mem[waddr] = wdata; dut_wr[waddr] = 1; end
        vectors++;
        if (ok) begin
          model_mem[a - BASE] = d; model_wr[a - BASE] = 1; exp_sum = exp_sum + d;
          if ({we, waddr, wdata, csum} !== {1'b1, 4'(a - BASE), d, exp_sum}) begin
            miscompares++;
            $display("FAIL rnd%0d_c%0d_write got we=%b waddr=%0d wdata=%h csum=%h want 1 %0d %h %h", t, c, we, waddr, wdata, csum, a - BASE, d, exp_sum);
          end
        end else begin
          if ({we, csum} !== {1'b0, exp_sum}) begin
            miscompares++;
            $display("FAIL rnd%0d_c%0d_nowrite got we=%b csum=%h want 0 %h", t, c, we, csum, exp_sum);
          end
        end
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0; step();
      vectors++;
      if ({done, loaded, we, csum} !== {1'b1, 1'b1, 1'b0, exp_sum}) begin
        miscompares++; $display("FAIL rnd%0d_done got done=%b loaded=%b we=%b csum=%h want 1 1 0 %h", t, done, loaded, we, csum, exp_sum);
      end
      step();
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if ({dut_wr[i], dut_mem[i]} !== {model_wr[i], model_mem[i]}) begin
        miscompares++;
        $display("FAIL rnd_mem%0d got written=%b data=%h want %b %h", i, dut_wr[i], dut_mem[i], model_wr[i], model_mem[i]);
      end
    end
  endtask

  task automatic test_clear_abort();
    int n = 0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    while (we !== 1'b1 && n < 8) begin step(); n++; end
    for (int k = 0; k <= 5; k++) begin
      vectors++;
      if ({we, waddr} !== {1'b1, 4'(k)}) begin
        miscompares++; $display("FAIL abort_pre%0d got we=%b waddr=%0d want 1 %0d", k, we, waddr, k);
      end
      if (k < 5) step();
    end
    ioctl_index = 8'd1; ioctl_download = 1'b1; step();
    vectors++;
    if ({we, busy} !== 2'b01) begin miscompares++; $display("FAIL abort_stop got we/busy=%b want 01", {we, busy}); end
    ioctl_wr = 1'b1; ioctl_addr = 25'(BASE + 7); ioctl_dout = 8'h77; step();
    vectors++;
    if ({we, waddr, wdata, csum} !== {1'b1, 4'd7, 8'h77, 8'h77}) begin
      miscompares++; $display("FAIL abort_load got we=%b waddr=%0d wdata=%h csum=%h want 1 7 77 77", we, waddr, wdata, csum);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0; step();
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL abort_done got %b want 1", done); end
    n = 0;
    while (we !== 1'b1 && n < 8) begin step(); n++; end
    vectors++;
    if (we !== 1'b1) begin miscompares++; $display("FAIL abort_restart timeout we=%b want 1", we); end
    for (int k = 0; k < DEPTH; k++) begin
      vectors++;
      if ({we, busy, waddr, wdata} !== {1'b1, 1'b1, 4'(k), 8'h00}) begin
        miscompares++;
        $display("FAIL restart_word%0d got we=%b busy=%b waddr=%0d wdata=%h want 1 1 %0d 00", k, we, busy, waddr, wdata, k);
      end
      step();
    end
    vectors++;
    if ({we, busy} !== 2'b00) begin miscompares++; $display("FAIL restart_end got we/busy=%b want 00", {we, busy}); end
  endtask

  task automatic test_reset_mid_load();
    ioctl_index = 8'd1; ioctl_download = 1'b1; step();
    ioctl_wr = 1'b1; ioctl_addr = 25'(BASE + 4); ioctl_dout = 8'h9E; clear_req = 1'b1; step();
    ioctl_wr = 1'b0; clear_req = 1'b0;
    vectors++;
    if (we !== 1'b1) begin miscompares++; $display("FAIL midload_write got we=%b want 1", we); end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({we, waddr, wdata, busy, done, loaded, csum} !== 24'h0) begin
      miscompares++; $display("FAIL midload_async_reset got %h want 000000", {we, waddr, wdata, busy, done, loaded, csum});
    end
    ioctl_download = 1'b0;
    step(); reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(BASE + (i % DEPTH)); ioctl_dout = 8'(i); step();
      vectors++;
      if ({we, busy} !== 2'b00) begin miscompares++; $display("FAIL post_reset%0d got we/busy=%b want 00", i, {we, busy}); end
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b1; step();
    ioctl_wr = 1'b1; ioctl_addr = 25'(BASE + 9); ioctl_dout = 8'hC3; step();
    vectors++;
    if ({we, waddr, wdata} !== {1'b1, 4'd9, 8'hC3}) begin
      miscompares++; $display("FAIL post_reset_new_load got we=%b waddr=%0d wdata=%h want 1 9 c3", we, waddr, wdata);
    end
    idle_inputs(); step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_load();
    test_out_of_range();
    test_wrong_index();
    test_random();
    test_clear_abort();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
